// File: rtl/cscore_sched.sv
// cscore_sched: round-robin scheduler sharing one streaming character-score
// matcher between N requesters. A grant is held for a whole packet (up to the
// char flagged last). The matcher is cleared before each packet, and its score
// is returned afterwards as a result tagged with the requester index.
// Optional build macro: SCHED_TIMEOUT_EN adds a stall counter. When the granted
// requester stalls for TIMEOUT cycles, the packet is aborted and reported.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for any request; round-robin pick from ptr
// CLEAR   | one-cycle matcher clear pulse before the packet
// STREAM  | forwarding granted requester's chars to the matcher
// DRAIN   | one spare cycle so the matcher registers the final char
// REPORT  | result strobe; advance round-robin pointer
module cscore_sched #(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [8*N-1:0]  req_char,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic [7:0]      m_char,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_clear,
    input  logic [7:0]      m_score,
    output logic            res_valid,
    output logic [ID_W-1:0] res_id,
    output logic [7:0]      res_score,
    output logic            res_abort,
    output logic            busy
);

    if (N < 2 || N > 8 || (1 << ID_W) < N || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("cscore_sched: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [7:0]      res_score_q, res_score_d;
    logic [ID_W-1:0] pick;
    logic            found;
    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_char;
    logic            xfer;

`ifdef SCHED_TIMEOUT_EN
    logic [7:0]      stall_q, stall_d;
    logic            res_abort_q, res_abort_d;
`endif

    assign g_valid = req_valid[grant_q];
    assign g_last  = req_last[grant_q];
    assign g_char  = req_char[8*int'(grant_q) +: 8];

    // Round-robin pick: first valid requester at or after the pointer, mod N.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req_valid[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Matcher-side handshake: only the granted requester is forwarded in STREAM.
    always_comb begin
        m_valid   = 1'b0;
        m_char    = '0;
        req_ready = '0;
        xfer      = 1'b0;
        if (state_q == S_STREAM) begin
            m_valid            = g_valid;
            m_char             = g_char;
            xfer               = g_valid & m_ready;
            req_ready[grant_q] = xfer;
        end
    end

    // Next-state logic; the result is captured on entry to REPORT so it is
    // stable while res_valid is high.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        res_id_d    = res_id_q;
        res_score_d = res_score_q;
`ifdef SCHED_TIMEOUT_EN
        stall_d     = stall_q;
        res_abort_d = res_abort_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
`ifdef SCHED_TIMEOUT_EN
                stall_d = '0;
`endif
            end
            S_STREAM: begin
                if (xfer) begin
`ifdef SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (g_last) begin
                        state_d = S_DRAIN;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                else if (!g_valid) begin
                    if (stall_q == 8'(TIMEOUT - 1)) begin
                        state_d     = S_REPORT;
                        res_id_d    = grant_q;
                        res_score_d = m_score;
                        res_abort_d = 1'b1;
                    end else begin
                        stall_d = stall_q + 8'd1;
                    end
                end
`endif
            end
            S_DRAIN: begin
                state_d     = S_REPORT;
                res_id_d    = grant_q;
                res_score_d = m_score;
`ifdef SCHED_TIMEOUT_EN
                res_abort_d = 1'b0;
`endif
            end
            S_REPORT: begin
                ptr_d   = (int'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset drops any packet in flight silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            res_id_q    <= '0;
            res_score_q <= '0;
`ifdef SCHED_TIMEOUT_EN
            stall_q     <= '0;
            res_abort_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            res_id_q    <= res_id_d;
            res_score_q <= res_score_d;
`ifdef SCHED_TIMEOUT_EN
            stall_q     <= stall_d;
            res_abort_q <= res_abort_d;
`endif
        end
    end

    assign m_clear   = (state_q == S_CLEAR);
    assign res_valid = (state_q == S_REPORT);
    assign busy      = (state_q != S_IDLE);
    assign res_id    = res_id_q;
    assign res_score = res_score_q;
`ifdef SCHED_TIMEOUT_EN
    assign res_abort = res_abort_q;
`else
    assign res_abort = 1'b0;
`endif

endmodule

// File: doc/cscore_sched.md
# cscore_sched

Round-robin scheduler that shares one streaming character-score matcher between N character sources. It grants the matcher to one requester for a whole packet, a run of characters ending at a char flagged `last`. It clears the matcher before each packet and captures the matcher's 8-bit score after the packet. It sits between the input character FIFOs and the single matcher instance, and returns a tagged result per packet.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `ID_W`, 2, width of requester index; must satisfy 2^ID_W >= N
- `TIMEOUT`, 16, stall limit in cycles; used only when `SCHED_TIMEOUT_EN` is defined

Ports:
- `clk`  in  1  single clock; everything is on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  N  requester i has a char available
- `req_char`  in  8*N  char of requester i in bits [8i+7:8i]
- `req_last`  in  N  char of requester i ends its packet
- `req_ready`  out  N  one-hot; char of the granted requester is consumed this cycle
- `m_char`  out  8  char to the matcher
- `m_valid`  out  1  `m_char` is valid this cycle
- `m_ready`  in  1  matcher accepts `m_char`
- `m_clear`  out  1  one-cycle matcher reset pulse
- `m_score`  in  8  matcher's registered score output
- `res_valid`  out  1  one-cycle result strobe
- `res_id`  out  ID_W  requester index of the result
- `res_score`  out  8  captured score
- `res_abort`  out  1  result is from an aborted packet (timeout only)
- `busy`  out  1  FSM is not in IDLE

## Operation
Rules:
- **Reset values:** all outputs are 0, state is IDLE, RR pointer is 0, grant register is 0.

FSM states: IDLE, CLEAR, STREAM, DRAIN, REPORT.
- **IDLE:**
  - If any `req_valid` is set, grant the first set index searching from pointer `p` upward, mod N.
  - Latch the grant and go to CLEAR.
  - Otherwise stay in IDLE.
- **CLEAR:**
  - `m_clear`=1 for exactly one cycle.
  - `m_valid`=0 and `req_ready`=0.
  - Next state is STREAM.
- **STREAM:**
  - `m_valid` = `req_valid[g]`; `m_char` = `req_char[g]`.
  - `req_ready[g]` = `m_valid & m_ready`; all other `req_ready` bits are 0.
  - A transfer is a cycle with `m_valid & m_ready`.
  - A transfer with `req_last[g]`=1 moves the FSM to DRAIN.
  - A transfer without `last` keeps the FSM in STREAM.
  - `req_last` is ignored on non-transfer cycles.
- **DRAIN:**
  - One idle cycle so the matcher registers the final char.
  - Next state is REPORT.
- **REPORT:**
  - `res_valid`=1, `res_id`=g, `res_score`=`m_score` (registered into the output), `res_abort`=0.
  - `p` <= (g+1) mod N.
  - Next state is IDLE.
- The grant never changes inside a packet. Other requesters' valids are ignored until IDLE.
- `res_id`/`res_score` hold their value until the next REPORT. `res_valid` is 1 only in REPORT.
- Index arithmetic is mod N, not mod 2^ID_W. `p` never exceeds N-1.

## Timing
- Overhead per packet: 1 arbitration cycle (IDLE→CLEAR), 1 CLEAR, 1 DRAIN, 1 REPORT.
- A packet of L chars with `m_ready` held at 1 and valid never dropped: `busy` is high for L+3 cycles.
- `res_valid` rises 2 cycles after the `last` transfer edge.
- A new grant can issue in the cycle after REPORT. Back-to-back packets are separated by exactly one IDLE cycle.
- A single-char packet (`last` on the first char) is legal. It gives CLEAR, 1 STREAM, DRAIN, REPORT.
- `reset` asserted in any state:
  - Next state is IDLE and all outputs return to reset values.
  - No result is emitted for the interrupted packet.
  - `m_clear` is not pulsed by reset itself.
- When `reset` and `req_valid` are both high, reset wins; arbitration starts in the first cycle after `reset` deasserts.

## Configuration
- **`SCHED_TIMEOUT_EN` defined:**
  - An 8-bit stall counter runs in STREAM. It increments on each cycle with `req_valid[g]`=0 and clears on any transfer.
  - When the counter reaches `TIMEOUT`, go directly to REPORT with `res_abort`=1 and `res_score`=`m_score`.
  - Advance `p` and release the grant.
  - Chars the requester sends afterwards form a new packet.
- **Not defined:**
  - No counter; the grant is held indefinitely.
  - `res_abort` is tied to 0.

## Test plan
- **Single requester:** requester 1 sends "cscore" with `last` on 'e', `m_ready`=1, model matcher returns 1 → CLEAR one cycle before 'c'; `res_valid` 2 cycles after 'e'; `res_id`=1, `res_score`=1; `busy` high for 9 cycles.
- **Fairness:** all 4 requesters continuously valid, each with a 2-char packet → grant order 0,1,2,3,0; no requester is granted twice within any 4 results.
- **Backpressure:** `m_ready` toggles 1,0,1,0 during a 3-char packet → exactly 3 transfers; `req_ready` is never high while `m_ready`=0; chars arrive in order.
- **Mid-packet reset:** `reset` pulses after 2 of 5 chars → `busy`=0 the next cycle; no `res_valid`; the next grant starts from requester 0.
- **Timeout (`SCHED_TIMEOUT_EN`, `TIMEOUT`=4):** requester 2 drops valid after 1 char → `res_valid` with `res_abort`=1, `res_id`=2, 4 stall cycles after the last transfer, then the grant moves to 3.
- **Single-char packet** from requester 3 while requester 0 waits → results are 3 then 0; there is exactly one IDLE cycle between the two packets.
